// File: rtl/bfly_pkg.sv
// Shared types for the butterfly result path: complex words, result entries, serializer states.
// Also holds the byte-select helper used to stream a result out MSB-first.
package bfly_pkg;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

  typedef struct packed {
    cplx_t a;
    cplx_t b;
  } bfly_res_t;

  localparam int BFLY_RES_BYTES = 16;
  localparam int BFLY_IN_BYTES  = 24;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Byte k of a result: A_re[31:24] is byte 0, B_im[7:0] is byte 15.
  function automatic logic [7:0] res_byte(input bfly_res_t e, input logic [3:0] k);
    logic [127:0] sh;
    sh = 128'(e) >> {4'd15 - k, 3'd0};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/bfly_res_fifo.sv
// Register FIFO of butterfly results. Exposes the head and the entry behind it so the
// serializer can roll straight into the next result without a bubble.
module bfly_res_fifo
  import bfly_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  bfly_res_t                    din,
  output bfly_res_t                    head,
  output bfly_res_t                    head_next,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  bfly_res_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_nx_s;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign pop_ok_s  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok_s = push & (~full | pop_ok_s);
  assign rd_nx_s   = rd_ptr_r + PTR_W'(1);
  assign head      = mem_r[rd_ptr_r];
  assign head_next = mem_r[rd_nx_s];

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_nx_s;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/bfly_result_serializer.sv
// Captures butterfly results into a small FIFO and streams each one out as 16 bytes
// over a valid/ready byte interface; results arriving while full are dropped and flagged.
module bfly_result_serializer
  import bfly_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  input  logic [WORD_W-1:0]           i_A_re,
  input  logic [WORD_W-1:0]           i_A_im,
  input  logic [WORD_W-1:0]           i_B_re,
  input  logic [WORD_W-1:0]           i_B_im,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last,
  output logic [$clog2(DEPTH+1)-1:0]  o_count,
  output logic                        o_full,
  output logic                        o_overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (WORD_W != 32) begin : g_word_w_check
    $error("bfly_result_serializer: WORD_W must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("bfly_result_serializer: DEPTH must be a power of two >= 2");
  end
  if ((BFLY_RES_BYTES % 8) != 0 || (BFLY_IN_BYTES % 8) != 0) begin : g_frame_check
    $error("bfly_result_serializer: frames must hold whole complex words");
  end

  ser_state_t       state_r, state_s;
  logic [3:0]       byte_cnt_r, byte_cnt_s;
  logic [7:0]       o_data_r, data_s;
  logic             o_valid_r, valid_s;
  logic             o_last_r, last_s;
  logic             overflow_r;
  bfly_res_t        entry_s, head_s, head_next_s, next_src_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s, empty_s;
  logic             transfer_s, pop_last_s, push_s, drop_s, more_s;

  assign entry_s    = {i_A_re, i_A_im, i_B_re, i_B_im};
  assign transfer_s = o_valid_r & i_ready;
  assign pop_last_s = transfer_s & o_last_r;
  assign push_s     = i_valid & (~full_s | pop_last_s);
  assign drop_s     = i_valid & full_s & ~pop_last_s;
  // After popping the head, another result is ready if one was queued behind it or arrives now.
  assign more_s     = (count_s > CNT_W'(1)) | push_s;
  assign next_src_s = (count_s > CNT_W'(1)) ? head_next_s : entry_s;

  bfly_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push_s),
    .pop       (pop_last_s),
    .din       (entry_s),
    .head      (head_s),
    .head_next (head_next_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Next-state and next-output logic; outputs are loaded one cycle ahead of presentation.
  always_comb begin
    state_s    = state_r;
    byte_cnt_s = byte_cnt_r;
    data_s     = o_data_r;
    valid_s    = o_valid_r;
    last_s     = o_last_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_s    = SEND;
          byte_cnt_s = 4'd0;
          data_s     = res_byte(head_s, 4'd0);
          valid_s    = 1'b1;
          last_s     = 1'b0;
        end else begin
          data_s  = 8'h00;
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      end
      SEND: begin
        if (transfer_s && o_last_r) begin
          byte_cnt_s = 4'd0;
          last_s     = 1'b0;
          if (more_s) begin
            data_s  = res_byte(next_src_s, 4'd0);
            valid_s = 1'b1;
          end else begin
            state_s = IDLE;
            data_s  = 8'h00;
            valid_s = 1'b0;
          end
        end else if (transfer_s) begin
          byte_cnt_s = byte_cnt_r + 4'd1;
          data_s     = res_byte(head_s, byte_cnt_r + 4'd1);
          last_s     = ((byte_cnt_r + 4'd1) == 4'(BFLY_RES_BYTES - 1));
        end else begin
          byte_cnt_s = byte_cnt_r;
          data_s     = o_data_r;
        end
      end
      default: begin
        state_s    = IDLE;
        byte_cnt_s = 4'd0;
        data_s     = 8'h00;
        valid_s    = 1'b0;
        last_s     = 1'b0;
      end
    endcase
  end

  // State, byte counter, output and overflow registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      byte_cnt_r <= 4'd0;
      o_data_r   <= 8'h00;
      o_valid_r  <= 1'b0;
      o_last_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      byte_cnt_r <= byte_cnt_s;
      o_data_r   <= data_s;
      o_valid_r  <= valid_s;
      o_last_r   <= last_s;
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign o_data     = o_data_r;
  assign o_valid    = o_valid_r;
  assign o_last     = o_last_r;
  assign o_count    = count_s;
  assign o_full     = full_s;
  assign o_overflow = overflow_r;

endmodule
